// File: rtl/branch_stat_pkg.sv
// -----------------------------------------------------------------------------
// branch_stat_pkg
// Shared types and constants for the branch statistics collector.
//   stat_state_e       : controller states (IDLE, RUN, DUMP, DONE)
//   DUMP_* constants   : word index carried on dump_id_o
//   HALT_INSN_DEFAULT  : jal x0,0 self-loop used by test programs to halt
// -----------------------------------------------------------------------------
package branch_stat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } stat_state_e;

    localparam logic [1:0] DUMP_CYCLES   = 2'd0;
    localparam logic [1:0] DUMP_BRANCHES = 2'd1;
    localparam logic [1:0] DUMP_MISSES   = 2'd2;
    localparam logic [1:0] DUMP_LAST_PC  = 2'd3;

    localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_006F;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (count -> 0)
//   clr    : synchronous clear, wins over inc
//   inc    : add one this cycle unless already saturated
//   count  : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority so a restart in the same cycle as an increment
    // always leaves the counter at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_stat_collector.sv
// -----------------------------------------------------------------------------
// branch_stat_collector
// Counts cycles, resolved branches and mispredictions from the core's
// predictor probe, detects program halt from the fetch stream, then streams
// the frozen results as four words over a valid/ready port.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i              : pulse; clear counters and start counting
//   br_instr_i/br_miss_i : branch resolved / mispredicted in EX/MEM
//   instr_i              : instruction in IF (halt detection)
//   t_instr_i            : PC of the EX/MEM instruction
//   dump_valid_o/ready_i : result stream handshake
//   dump_id_o/data_o     : 0 cycles, 1 branches, 2 misses, 3 last-miss PC
//   busy_o, done_o       : in RUN / in DONE
// CNT_W must be at least 32 so the PC word fits without truncation.
// -----------------------------------------------------------------------------
module branch_stat_collector
    import branch_stat_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] HALT_INSN   = HALT_INSN_DEFAULT,
    parameter int          HALT_REPEAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             br_instr_i,
    input  logic             br_miss_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      t_instr_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [1:0]       dump_id_o,
    output logic [CNT_W-1:0] dump_data_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [7:0] HALT_LAST = 8'(HALT_REPEAT - 1);

    stat_state_e      state;
    stat_state_e      next_state;
    logic [7:0]       halt_run;
    logic [1:0]       idx;
    logic [31:0]      last_miss_pc;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;

    logic cnt_clr;
    logic count_en;
    logic is_halt;
    logic halt_hit;
    logic xfer;
    logic miss_ev;

    // start_i is honoured everywhere except while a dump is in flight; a
    // start in RUN restarts, so counting is suppressed in that cycle.
    assign cnt_clr  = start_i && (state != DUMP);
    assign count_en = (state == RUN) && !start_i;
    assign is_halt  = (instr_i == HALT_INSN);
    assign halt_hit = count_en && is_halt && (halt_run == HALT_LAST);
    assign xfer     = dump_valid_o && dump_ready_i;
    assign miss_ev  = count_en && br_instr_i && br_miss_i;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (cnt_clr),
        .inc    (count_en),
        .count  (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (cnt_clr),
        .inc    (count_en && br_instr_i),
        .count  (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (cnt_clr),
        .inc    (miss_ev),
        .count  (miss_cnt)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A restart in RUN takes priority over a halt seen in
    // the same cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_i) next_state = RUN;
            end
            RUN: begin
                if (start_i)       next_state = RUN;
                else if (halt_hit) next_state = DUMP;
            end
            DUMP: begin
                if (xfer && (idx == DUMP_LAST_PC)) next_state = DONE;
            end
            DONE: begin
                if (start_i) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // Length of the current run of halt instructions; saturates so a long
    // self-loop cannot wrap back to a small value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_run <= '0;
        end else if (cnt_clr) begin
            halt_run <= '0;
        end else if (count_en) begin
            if (!is_halt) begin
                halt_run <= '0;
            end else if (halt_run != 8'hFF) begin
                halt_run <= halt_run + 8'd1;
            end
        end
    end

    // PC of the most recent mispredicted branch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_miss_pc <= '0;
        end else if (cnt_clr) begin
            last_miss_pc <= '0;
        end else if (miss_ev) begin
            last_miss_pc <= t_instr_i;
        end
    end

    // Dump word index: parked at 0 outside DUMP so the first word is ready on
    // the edge that enters DUMP, then advances once per accepted word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx <= DUMP_CYCLES;
        end else if (state != DUMP) begin
            idx <= DUMP_CYCLES;
        end else if (xfer) begin
            idx <= idx + 2'd1;
        end
    end

    // Counters are frozen in DUMP, so selecting by the registered index keeps
    // the payload stable while the sink stalls.
    always_comb begin
        dump_data_o = '0;
        if (dump_valid_o) begin
            unique case (idx)
                DUMP_CYCLES:   dump_data_o = cycle_cnt;
                DUMP_BRANCHES: dump_data_o = branch_cnt;
                DUMP_MISSES:   dump_data_o = miss_cnt;
                DUMP_LAST_PC:  dump_data_o = CNT_W'(last_miss_pc);
                default:       dump_data_o = '0;
            endcase
        end
    end

    // Valid follows the state register, so reset drops it asynchronously.
    assign dump_valid_o = (state == DUMP);
    assign dump_id_o    = dump_valid_o ? idx : DUMP_CYCLES;
    assign busy_o       = (state == RUN);
    assign done_o       = (state == DONE);

endmodule

// File: tb/tb_branch_stat_collector.sv
// -----------------------------------------------------------------------------
// tb_branch_stat_collector
// Directed scenarios plus randomized rounds against a queue-based model of
// the collector; a small 3-bit sat_counter instance exercises saturation.
// -----------------------------------------------------------------------------
module tb_branch_stat_collector;
    import branch_stat_pkg::*;

    localparam logic [31:0] HALT = 32'h0000_006F;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam longint      CMAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        br_instr = 1'b0;
    logic        br_miss = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] t_instr = 32'h0;
    logic        dump_ready = 1'b0;
    logic        dump_valid;
    logic [1:0]  dump_id;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;

    logic        sat_clr = 1'b0;
    logic        sat_inc = 1'b0;
    logic [2:0]  sat_count;

    int checks = 0;
    int failures = 0;

    // Behavioural model: phase 0 idle, 1 counting, 2 streaming, 3 finished.
    int          m_phase = 0;
    longint      m_cycles = 0;
    longint      m_branches = 0;
    longint      m_misses = 0;
    logic [31:0] m_pc = 32'h0;
    int          m_run = 0;
    logic [31:0] m_words[$];
    int          m_sat = 0;

    always #5 clk = ~clk;

    branch_stat_collector #(.CNT_W(32), .HALT_INSN(HALT), .HALT_REPEAT(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .br_instr_i   (br_instr),
        .br_miss_i    (br_miss),
        .instr_i      (instr),
        .t_instr_i    (t_instr),
        .dump_valid_o (dump_valid),
        .dump_ready_i (dump_ready),
        .dump_id_o    (dump_id),
        .dump_data_o  (dump_data),
        .busy_o       (busy),
        .done_o       (done)
    );

    sat_counter #(.W(3)) u_sat (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr    (sat_clr),
        .inc    (sat_inc),
        .count  (sat_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic longint sat32(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic modelClear();
        m_cycles   = 0;
        m_branches = 0;
        m_misses   = 0;
        m_pc       = 32'h0;
        m_run      = 0;
    endtask

    // Model update at each rising edge, then compare every output 1 ns later.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            modelClear();
            m_words.delete();
            m_sat = 0;
        end else begin
            case (m_phase)
                0, 3: begin
                    if (start) begin
                        modelClear();
                        m_phase = 1;
                    end
                end
                1: begin
                    if (start) begin
                        modelClear();
                    end else begin
                        m_cycles = sat32(m_cycles + 1);
                        if (br_instr) m_branches = sat32(m_branches + 1);
                        if (br_instr && br_miss) begin
                            m_misses = sat32(m_misses + 1);
                            m_pc = t_instr;
                        end
                        m_run = (instr == HALT) ? m_run + 1 : 0;
                        if (m_run >= 4) begin
                            m_words = {32'(m_cycles), 32'(m_branches), 32'(m_misses), m_pc};
                            m_phase = 2;
                        end
                    end
                end
                default: begin
                    if (dump_ready) begin
                        void'(m_words.pop_front());
                        if (m_words.size() == 0) m_phase = 3;
                    end
                end
            endcase
            if (sat_clr) m_sat = 0;
            else if (sat_inc && m_sat < 7) m_sat = m_sat + 1;
        end
        #1;
        checkOutput("busy", 32'(busy), 32'(m_phase == 1));
        checkOutput("done", 32'(done), 32'(m_phase == 3));
        checkOutput("valid", 32'(dump_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            checkOutput("dump_id", 32'(dump_id), 32'(4 - m_words.size()));
            checkOutput("dump_data", dump_data, m_words[0]);
        end
        checkOutput("sat_count", 32'(sat_count), 32'(m_sat));
    end

    // Drive one cycle of inputs, then wait for the following falling edge.
    task automatic applyStimulus(input logic st, input logic br, input logic miss,
                                 input logic [31:0] ins, input logic [31:0] pc,
                                 input logic rdy);
        start      = st;
        br_instr   = br;
        br_miss    = miss;
        instr      = ins;
        t_instr    = pc;
        dump_ready = rdy;
        @(negedge clk);
    endtask

    // Accept dump words from index 'first' with ready held high, checking
    // each against hand-computed literals, then check DONE.
    task automatic drainFrom(input int first, input logic [31:0] exp_words [4], input string tag);
        for (int i = first; i < 4; i++) begin
            checkOutput({tag, "_valid"}, 32'(dump_valid), 32'd1);
            checkOutput({tag, "_id"}, 32'(dump_id), 32'(i));
            checkOutput({tag, "_data"}, dump_data, exp_words[i]);
            applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b1);
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_valid_off"}, 32'(dump_valid), 32'd0);
    endtask

    initial begin
        int bound;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(dump_valid), 32'd0);
        checkOutput("rst_data", dump_data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Saturating sub-counter: 10 increments on a 3-bit counter stop at 7.
        sat_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        sat_clr = 1'b0;
        sat_inc = 1'b1;
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        checkOutput("sat_top", 32'(sat_count), 32'd7);
        sat_inc = 1'b0;
        sat_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        sat_clr = 1'b0;
        checkOutput("sat_clr", 32'(sat_count), 32'd0);

        // Basic run: branches on cycles 2, 5, 7, miss on 5 at PC 0x40.
        applyStimulus(1'b1, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 10; k++)
            applyStimulus(1'b0, (k == 2 || k == 5 || k == 7), (k == 5), NOP,
                          (k == 5) ? 32'h40 : 32'(k * 4), 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b0);
        drainFrom(0, '{32'd14, 32'd3, 32'd1, 32'h40}, "t1");

        // Misses without a branch are ignored; last PC cleared by start.
        applyStimulus(1'b1, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, NOP, 32'h99, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b0);
        drainFrom(0, '{32'd9, 32'd0, 32'd0, 32'd0}, "t2");

        // Interrupted halt run, then stall the sink on word 1.
        applyStimulus(1'b1, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, HALT, 32'h10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h14, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, HALT, 32'h123, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b0);
        checkOutput("t3_still_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b0);
        checkOutput("t3_w0", dump_data, 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            checkOutput("t3_stall_id", 32'(dump_id), 32'd1);
            checkOutput("t3_stall_data", dump_data, 32'd2);
            applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b0);
        end
        drainFrom(1, '{32'd8, 32'd2, 32'd1, 32'h123}, "t3");

        // Reset in the middle of the dump, then a fresh run.
        applyStimulus(1'b1, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, NOP, 32'h80, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b1);
        checkOutput("t6_at_idx2", 32'(dump_id), 32'd2);
        dump_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(dump_valid), 32'd0);
        checkOutput("t6_rst_id", 32'(dump_id), 32'd0);
        checkOutput("t6_rst_data", dump_data, 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, HALT, 32'h0, 1'b0);
        drainFrom(0, '{32'd7, 32'd0, 32'd0, 32'd0}, "t6");

        // Randomized rounds checked every cycle by the model.
        for (int r = 0; r < 25; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, NOP, 32'h0, 1'($urandom_range(0, 1)));
            for (int j = 0; j < int'($urandom_range(3, 30)); j++) begin
                if (m_phase != 1) break;
                applyStimulus(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0) ? HALT : 32'($urandom),
                              32'($urandom), 1'($urandom_range(0, 1)));
            end
            bound = 0;
            while (m_phase == 1 && bound < 50) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              HALT, 32'($urandom), 1'($urandom_range(0, 1)));
                bound++;
            end
            bound = 0;
            while (m_phase == 2 && bound < 200) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              32'($urandom), 32'($urandom), ($urandom_range(0, 9) < 6));
                bound++;
            end
            checkOutput("rnd_reached_done", 32'(done), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
